// File: rtl/uart_mmio_master.sv
// UART byte-stream debug bridge: parses 'R'/'W' frames, issues one MMIO transaction at a time,
// and replies with the read data (LSB first), 'K' for a completed write, or 'E' for a bad opcode.
module uart_mmio_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  OP_READ        = 8'h52,
   parameter logic [7:0]  OP_WRITE       = 8'h57,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_req_valid,
   input  logic        i_req_ready,
   output logic [31:0] o_req_addr,
   output logic [31:0] o_req_wdata,
   output logic [3:0]  o_req_wmask,
   input  logic        i_resp_valid,
   input  logic [31:0] i_resp_rdata,
   output logic        o_resp_ready,
   output logic        o_busy,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_REQ  = 3'd3,
      S_RESP = 3'd4,
      S_TX   = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q;
   logic        is_write_q, is_err_q;
   logic [31:0] addr_q, wdata_q, rdata_q, tmo_q;
   logic        rx_fire, tx_fire, tmo_hit, last_tx, op_known;

   // Handshakes: a byte/beat moves only in a cycle where both valid and ready are high.
   assign rx_fire  = i_rx_valid && o_rx_ready;
   assign tx_fire  = o_tx_valid && i_tx_ready;
   assign tmo_hit  = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
   assign last_tx  = is_err_q || is_write_q || (idx_q == 2'd3);
   assign op_known = (i_rx_data == OP_READ) || (i_rx_data == OP_WRITE);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (rx_fire) state_d = op_known ? S_ADDR : S_TX;
         S_ADDR: begin
            if (rx_fire && idx_q == 2'd3) state_d = is_write_q ? S_DATA : S_REQ;
            else if (!rx_fire && tmo_hit) state_d = S_IDLE;
         end
         S_DATA: begin
            if (rx_fire && idx_q == 2'd3) state_d = S_REQ;
            else if (!rx_fire && tmo_hit) state_d = S_IDLE;
         end
         S_REQ:  if (i_req_ready) state_d = S_RESP;
         S_RESP: if (i_resp_valid) state_d = S_TX;
         S_TX:   if (tx_fire && last_tx) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_rx_ready   = 1'b0;
      o_req_valid  = 1'b0;
      o_resp_ready = 1'b0;
      o_tx_valid   = 1'b0;
      o_tx_data    = 8'h00;
      case (state_q)
         S_IDLE, S_ADDR, S_DATA: o_rx_ready = !i_rst;
         S_REQ:  o_req_valid  = 1'b1;
         S_RESP: o_resp_ready = 1'b1;
         S_TX: begin
            o_tx_valid = 1'b1;
            if (is_err_q)        o_tx_data = ERR_BYTE;
            else if (is_write_q) o_tx_data = ACK_BYTE;
            else                 o_tx_data = rdata_q[{idx_q, 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   // The 2-bit index wraps to 0 after byte 3, so it is ready for the next field or reply.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_q      <= 2'd0;
         is_write_q <= 1'b0;
         is_err_q   <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         tmo_q      <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: if (rx_fire) begin
               idx_q      <= 2'd0;
               tmo_q      <= 32'h0;
               wdata_q    <= 32'h0;
               is_write_q <= (i_rx_data == OP_WRITE);
               is_err_q   <= !op_known;
            end
            S_ADDR: if (rx_fire) begin
               addr_q[{idx_q, 3'b000} +: 8] <= i_rx_data;
               idx_q <= idx_q + 2'd1;
               tmo_q <= 32'h0;
            end else begin
               tmo_q <= tmo_q + 32'h1;
            end
            S_DATA: if (rx_fire) begin
               wdata_q[{idx_q, 3'b000} +: 8] <= i_rx_data;
               idx_q <= idx_q + 2'd1;
               tmo_q <= 32'h0;
            end else begin
               tmo_q <= tmo_q + 32'h1;
            end
            S_RESP: if (i_resp_valid) rdata_q <= i_resp_rdata;
            S_TX:   if (tx_fire) idx_q <= idx_q + 2'd1;
            default: ;
         endcase
      end
   end

   assign o_req_addr  = addr_q;
   assign o_req_wdata = wdata_q;
   assign o_req_wmask = {4{is_write_q}};
   assign o_busy      = (state_q != S_IDLE);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_mmio_master.sv
// Bench for uart_mmio_master: drives command frames, models an MMIO slave and a TX sink,
// and scoreboards every bus request and reply byte against expectations queued at drive time.
module tb_uart_mmio_master;

   localparam int unsigned TMO = 40;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_req_valid;
   logic        i_req_ready;
   logic [31:0] o_req_addr;
   logic [31:0] o_req_wdata;
   logic [3:0]  o_req_wmask;
   logic        i_resp_valid;
   logic [31:0] i_resp_rdata;
   logic        o_resp_ready;
   logic        o_busy;
   logic [2:0]  o_dbg_state;

   uart_mmio_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
      .o_req_wdata(o_req_wdata), .o_req_wmask(o_req_wmask),
      .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .o_resp_ready(o_resp_ready),
      .o_busy(o_busy), .o_dbg_state(o_dbg_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   logic [67:0] exp_req_q[$];     // {addr, wdata, wmask}
   logic [7:0]  exp_tx_q[$];
   logic [31:0] slave_rdata_q[$];

   int req_delay = 0;
   int resp_delay = 0;
   int tx_mode = 0;               // 0: always ready, 1: toggling, 2: random

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // MMIO slave model
   logic [31:0] slave_rd;
   initial begin
      i_req_ready  = 1'b0;
      i_resp_valid = 1'b0;
      i_resp_rdata = 32'h0;
      forever begin
         @(posedge i_clk); #1;
         if (o_req_valid && !i_rst) begin
            repeat (req_delay) begin @(posedge i_clk); #1; end
            i_req_ready = 1'b1;
            @(posedge i_clk); #1;
            i_req_ready = 1'b0;
            repeat (resp_delay) begin @(posedge i_clk); #1; end
            slave_rd = (slave_rdata_q.size() != 0) ? slave_rdata_q.pop_front() : 32'hDEAD_BEEF;
            i_resp_rdata = slave_rd;
            i_resp_valid = 1'b1;
            @(posedge i_clk); #1;
            i_resp_valid = 1'b0;
         end
      end
   end

   // TX sink ready pattern
   initial begin
      i_tx_ready = 1'b1;
      forever begin
         @(posedge i_clk); #1;
         case (tx_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = ~i_tx_ready;
            default: i_tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitors: sample on the falling edge, away from the active edge
   logic        req_hold = 1'b0, tx_hold = 1'b0;
   logic [67:0] hold_req, exp_req;
   logic [7:0]  hold_tx, exp_tx;
   logic [31:0] last_req_addr = 32'h0;

   always @(negedge i_clk) begin
      if (i_rst) begin
         req_hold = 1'b0;
         tx_hold  = 1'b0;
      end else begin
         if (req_hold) begin
            check("req_valid_held", 32'(o_req_valid), 32'd1);
            check("req_addr_stable", o_req_addr, hold_req[67:36]);
            check("req_wdata_stable", o_req_wdata, hold_req[35:4]);
         end
         if (o_req_valid && i_req_ready) begin
            check("req_queued", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) begin
               exp_req = exp_req_q.pop_front();
               check("req_addr", o_req_addr, exp_req[67:36]);
               check("req_wdata", o_req_wdata, exp_req[35:4]);
               check("req_wmask", 32'(o_req_wmask), 32'(exp_req[3:0]));
            end
            last_req_addr = o_req_addr;
         end
         req_hold = o_req_valid && !i_req_ready;
         hold_req = {o_req_addr, o_req_wdata, o_req_wmask};
         if (o_resp_ready) check("resp_addr_stable", o_req_addr, last_req_addr);

         if (tx_hold) begin
            check("tx_valid_held", 32'(o_tx_valid), 32'd1);
            check("tx_data_stable", 32'(o_tx_data), 32'(hold_tx));
         end
         if (o_tx_valid && i_tx_ready) begin
            check("tx_queued", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) begin
               exp_tx = exp_tx_q.pop_front();
               check("tx_byte", 32'(o_tx_data), 32'(exp_tx));
            end
         end
         tx_hold = o_tx_valid && !i_tx_ready;
         hold_tx = o_tx_data;
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      forever begin
         @(negedge i_clk);
         if (o_rx_ready) break;
         n++;
         if (n > 2000) begin
            check("rx_accept", 32'(o_rx_ready), 32'd1);
            break;
         end
      end
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic expect_reply);
      exp_req_q.push_back({addr, wr ? data : 32'h0, wr ? 4'hF : 4'h0});
      slave_rdata_q.push_back(wr ? 32'h0 : data);
      if (expect_reply) begin
         if (wr) exp_tx_q.push_back(8'h4B);
         else for (int k = 0; k < 4; k++) exp_tx_q.push_back(data[8*k +: 8]);
      end
      send_byte(wr ? 8'h57 : 8'h52);
      for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
      if (wr) for (int k = 0; k < 4; k++) send_byte(data[8*k +: 8]);
      check("req_latency", 32'(o_req_valid), 32'd1);
   endtask

   task automatic send_bad_op(input logic [7:0] op);
      exp_tx_q.push_back(8'h45);
      send_byte(op);
      check("err_no_req", 32'(o_req_valid), 32'd0);
      check("err_busy", 32'(o_busy), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((o_busy || exp_tx_q.size() != 0) && n < budget) begin
         @(posedge i_clk); #1;
         n++;
      end
      check("idle_reached", 32'(o_busy), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_valid"}, 32'(o_req_valid), 32'd0);
      check({tag, "_req_addr"}, o_req_addr, 32'd0);
      check({tag, "_req_wdata"}, o_req_wdata, 32'd0);
      check({tag, "_req_wmask"}, 32'(o_req_wmask), 32'd0);
      check({tag, "_resp_ready"}, 32'(o_resp_ready), 32'd0);
      check({tag, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
   endtask

   logic [7:0]  rnd_op;
   logic [31:0] rnd_addr, rnd_data;
   int          kind, n;

   initial begin
      i_rst      = 1'b1;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      check("rx_ready_in_reset", 32'(o_rx_ready), 32'd0);
      check_outputs_zero("reset");
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      check("rx_ready_idle", 32'(o_rx_ready), 32'd1);

      // write: 57 18 00 00 30 0F 00 00 00
      send_frame(1'b1, 32'h3000_0018, 32'h0000_000F, 1'b1);
      wait_idle(200);

      // read: 52 04 00 00 30, reply 41 00 00 80
      send_frame(1'b0, 32'h3000_0004, 32'h8000_0041, 1'b1);
      wait_idle(200);

      // unknown opcode, then a normal read
      send_bad_op(8'h11);
      wait_idle(200);
      send_frame(1'b0, 32'h1234_5678, 32'hCAFE_F00D, 1'b1);
      wait_idle(200);

      // partial write frame then silence
      send_byte(8'h57);
      send_byte(8'h18);
      send_byte(8'h00);
      repeat (20) begin @(posedge i_clk); #1; end
      check("timeout_still_busy", 32'(o_busy), 32'd1);
      repeat (25) begin @(posedge i_clk); #1; end
      check("timeout_dropped", 32'(o_busy), 32'd0);
      check("timeout_no_req", 32'(exp_req_q.size()), 32'd0);
      send_frame(1'b0, 32'h3000_0008, 32'h0102_0304, 1'b1);
      wait_idle(200);

      // slow slave and toggling TX sink, two frames back to back
      req_delay  = 5;
      resp_delay = 3;
      tx_mode    = 1;
      send_frame(1'b1, 32'hA5A5_0010, 32'h5A5A_C3C3, 1'b1);
      send_frame(1'b0, 32'h0000_0FFC, 32'h89AB_CDEF, 1'b1);
      wait_idle(400);

      // reset while waiting in RESP, then a write completes normally
      req_delay  = 0;
      resp_delay = 8;
      tx_mode    = 0;
      send_frame(1'b0, 32'h4000_0000, 32'h7777_7777, 1'b0);
      n = 0;
      while (!o_resp_ready && n < 100) begin @(posedge i_clk); #1; n++; end
      check("reached_resp", 32'(o_resp_ready), 32'd1);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      check("rx_ready_rst_high", 32'(o_rx_ready), 32'd0);
      @(posedge i_clk); #1;
      check_outputs_zero("midrst");
      i_rst = 1'b0;
      repeat (20) begin @(posedge i_clk); #1; end
      resp_delay = 0;
      send_frame(1'b1, 32'h4000_0004, 32'h0000_00AA, 1'b1);
      wait_idle(200);

      // random frames, back to back, random slave delays and TX backpressure
      tx_mode = 2;
      for (int i = 0; i < 8; i++) begin
         kind       = $urandom_range(0, 2);
         req_delay  = $urandom_range(0, 4);
         resp_delay = $urandom_range(0, 4);
         rnd_addr   = $urandom();
         rnd_data   = $urandom();
         rnd_op     = 8'($urandom_range(0, 8'h4F));
         if (kind == 2) send_bad_op(rnd_op);
         else           send_frame(kind == 1, rnd_addr, rnd_data, 1'b1);
      end
      wait_idle(2000);

      check("req_drain", 32'(exp_req_q.size()), 32'd0);
      check("tx_drain", 32'(exp_tx_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
